nios_fprint_cpu_dct_packer: RTL and testbench

NIOS_FPRINT_CPU_DCT_PACKER -- requirements
Module: nios_fprint_cpu_dct_packer

---
 rtl/nios_fprint_dct_pkg.sv | 16 +
 rtl/nios_fprint_cpu_dct_packer.sv | 135 +++++++++++++
 tb/tb_nios_fprint_cpu_dct_packer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_fprint_dct_pkg.sv
// Shared definitions for the trace-atom DCT packer.
// Holds the session FSM encoding and the atom / packed-word widths.
package nios_fprint_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int DCT_BUF_W = 30;
    localparam int DCT_CNT_W = 4;

    // Trace session state: collecting, draining after an end request, done.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ENDING = 2'd1,
        ST_ENDED  = 2'd2
    } dct_state_t;

endpackage

// File: rtl/nios_fprint_cpu_dct_packer.sv
// Packs 2-bit CPU trace atoms into 30-bit words (atom k in bits [2k+1:2k]).
// An accumulator collects atoms; a single holding register presents the word.
// Output handshake: dct_valid stays high until out_ready is sampled high, and
// dct_buffer/dct_count do not change while dct_valid=1 and out_ready=0. A new
// word may be loaded in the same cycle the previous one is accepted.
// Optional feature: define NIOS_FPRINT_DCT_DROP_CNT_EN to add drop_count[15:0],
// a saturating count of atoms dropped because both stages were occupied.
module nios_fprint_cpu_dct_packer
    import nios_fprint_dct_pkg::*;
#(
    parameter int MAX_ATOMS = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 atom_valid,
    input  logic [ATOM_W-1:0]    atom_data,
    input  logic                 flush,
    input  logic                 end_req,
    input  logic                 out_ready,
    output logic                 dct_valid,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 test_ending,
    output logic                 test_has_ended
`ifdef NIOS_FPRINT_DCT_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    localparam logic [DCT_CNT_W-1:0] CNT_MAX = DCT_CNT_W'(MAX_ATOMS);

    dct_state_t             state, state_n;
    logic [DCT_BUF_W-1:0]   acc_buf, acc_buf_n, merge_buf, word_buf;
    logic [DCT_CNT_W-1:0]   acc_cnt, acc_cnt_n, merge_cnt, word_cnt;
    logic                   flush_pend;
    logic                   out_free, atom_acc, flush_new, flush_req;
    logic                   acc_full, xfer, drop;

    // Holding register can take a new word if empty or being accepted now.
    assign out_free  = !dct_valid || out_ready;
    // Atoms are only taken while running; end_req in the same cycle still
    // sees ST_RUN, so the coincident atom is kept.
    assign atom_acc  = atom_valid && (state == ST_RUN);
    assign flush_new = flush && (state == ST_RUN) && (acc_cnt != '0);
    assign flush_req = flush_pend || flush_new || (state == ST_ENDING);
    assign acc_full  = (acc_cnt == CNT_MAX);

    assign test_ending    = (state == ST_ENDING);
    assign test_has_ended = (state == ST_ENDED);

    // Merge the arriving atom and decide whether a word moves to the output.
    always_comb begin
        merge_buf = acc_buf;
        merge_cnt = acc_cnt;
        word_buf  = acc_buf;
        word_cnt  = acc_cnt;
        acc_buf_n = acc_buf;
        acc_cnt_n = acc_cnt;
        xfer      = 1'b0;
        drop      = 1'b0;
        if (acc_full) begin
            // A full accumulator leaves first; the new atom restarts at slot 0.
            if (out_free) begin
                xfer      = 1'b1;
                acc_buf_n = atom_acc ? DCT_BUF_W'(atom_data) : '0;
                acc_cnt_n = atom_acc ? DCT_CNT_W'(1) : '0;
            end else begin
                drop = atom_acc;
            end
        end else begin
            if (atom_acc) begin
                merge_buf = acc_buf | (DCT_BUF_W'(atom_data) << {acc_cnt, 1'b0});
                merge_cnt = acc_cnt + DCT_CNT_W'(1);
            end
            word_buf = merge_buf;
            word_cnt = merge_cnt;
            if (out_free && ((merge_cnt == CNT_MAX) || (flush_req && merge_cnt != '0))) begin
                xfer      = 1'b1;
                acc_buf_n = '0;
                acc_cnt_n = '0;
            end else begin
                acc_buf_n = merge_buf;
                acc_cnt_n = merge_cnt;
            end
        end
    end

    // Session FSM: end request drains everything, then stays ended.
    always_comb begin
        state_n = state;
        case (state)
            ST_RUN:    if (end_req) state_n = ST_ENDING;
            ST_ENDING: if (acc_cnt == '0 && !dct_valid) state_n = ST_ENDED;
            default:   state_n = ST_ENDED;
        endcase
    end

    // Accumulator, pending flush, FSM and output holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RUN;
            acc_buf    <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            dct_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
        end else begin
            state      <= state_n;
            acc_buf    <= acc_buf_n;
            acc_cnt    <= acc_cnt_n;
            flush_pend <= xfer ? 1'b0 : (flush_pend || flush_new);
            if (xfer) begin
                dct_valid  <= 1'b1;
                dct_buffer <= word_buf;
                dct_count  <= word_cnt;
            end else if (out_ready) begin
                dct_valid  <= 1'b0;
            end
        end
    end

`ifdef NIOS_FPRINT_DCT_DROP_CNT_EN
    // Saturating count of atoms lost to a full accumulator behind a stalled output.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nios_fprint_cpu_dct_packer.sv
// Directed self-checking bench for nios_fprint_cpu_dct_packer.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_nios_fprint_cpu_dct_packer;

    logic        clk;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        flush;
    logic        end_req;
    logic        out_ready;
    logic        dct_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
`ifdef NIOS_FPRINT_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks;
    int errors;

    nios_fprint_cpu_dct_packer #(.MAX_ATOMS(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom_data      (atom_data),
        .flush          (flush),
        .end_req        (end_req),
        .out_ready      (out_ready),
        .dct_valid      (dct_valid),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef NIOS_FPRINT_DCT_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        atom_valid = 1'b0;
        atom_data  = 2'd0;
        flush      = 1'b0;
        end_req    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_atom(input logic [1:0] a);
        atom_valid = 1'b1;
        atom_data  = a;
        step();
        atom_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        out_ready = 1'b1;
        do_reset();
        checks++;
        if ({dct_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b buf=%0h cnt=%0d e=%0b he=%0b expected all zero",
                     dct_valid, dct_buffer, dct_count, test_ending, test_has_ended);
        end
    endtask

    task automatic test_full_word();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_atom(2'b01);
        chk("full_valid", 32'(dct_valid), 32'd1);
        chk("full_buf",   32'(dct_buffer), 32'h15555555);
        chk("full_cnt",   32'(dct_count), 32'd15);
        step();
        chk("full_accepted", 32'(dct_valid), 32'd0);
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b1;
        send_atom(2'd3);
        send_atom(2'd2);
        send_atom(2'd1);
        chk("flush_none_yet", 32'(dct_valid), 32'd0);
        pulse_flush();
        chk("flush_valid", 32'(dct_valid), 32'd1);
        chk("flush_buf_321", 32'(dct_buffer), 32'h0000001B);
        chk("flush_cnt", 32'(dct_count), 32'd3);
        step();
        send_atom(2'd3);
        send_atom(2'd1);
        send_atom(2'd2);
        pulse_flush();
        chk("flush_buf_312", 32'(dct_buffer), 32'h00000027);
        chk("flush_cnt2", 32'(dct_count), 32'd3);
        step();
        // Flush with an empty accumulator must not produce a word or linger.
        pulse_flush();
        chk("flush_empty", 32'(dct_valid), 32'd0);
        send_atom(2'd2);
        chk("flush_not_pending", 32'(dct_valid), 32'd0);
        pulse_flush();
        chk("flush_single_buf", 32'(dct_buffer), 32'h00000002);
        chk("flush_single_cnt", 32'(dct_count), 32'd1);
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) send_atom(2'b01);
        for (int i = 0; i < 15; i++) send_atom(2'b10);
        send_atom(2'b11);
        step();
        step();
        chk("bp_held_valid", 32'(dct_valid), 32'd1);
        chk("bp_held_buf", 32'(dct_buffer), 32'h15555555);
        chk("bp_held_cnt", 32'(dct_count), 32'd15);
`ifdef NIOS_FPRINT_DCT_DROP_CNT_EN
        chk("bp_drop_count", 32'(drop_count), 32'd1);
`endif
        out_ready = 1'b1;
        step();
        chk("bp_word2_valid", 32'(dct_valid), 32'd1);
        chk("bp_word2_buf", 32'(dct_buffer), 32'h2AAAAAAA);
        chk("bp_word2_cnt", 32'(dct_count), 32'd15);
        step();
        chk("bp_drained", 32'(dct_valid), 32'd0);
    endtask

    task automatic test_end();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_atom(2'd3);
        // Fifth atom arrives together with the end request and must be kept.
        atom_valid = 1'b1;
        atom_data  = 2'd3;
        end_req    = 1'b1;
        step();
        atom_valid = 1'b0;
        end_req    = 1'b0;
        chk("end_ending", 32'(test_ending), 32'd1);
        send_atom(2'd1);
        chk("end_word_valid", 32'(dct_valid), 32'd1);
        chk("end_word_cnt", 32'(dct_count), 32'd5);
        chk("end_word_buf", 32'(dct_buffer), 32'h000003FF);
        step();
        chk("end_still_ending", 32'(test_ending), 32'd1);
        step();
        chk("end_has_ended", 32'(test_has_ended), 32'd1);
        chk("end_ending_low", 32'(test_ending), 32'd0);
        for (int i = 0; i < 16; i++) send_atom(2'd2);
        pulse_flush();
        step();
        chk("end_atoms_ignored", 32'(dct_valid), 32'd0);
        chk("end_sticky", 32'(test_has_ended), 32'd1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send_atom(2'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({dct_valid, dct_buffer, dct_count, test_ending, test_has_ended} !== 36'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%0b buf=%0h cnt=%0d expected all zero",
                     dct_valid, dct_buffer, dct_count);
        end
        send_atom(2'd1);
        send_atom(2'd1);
        pulse_flush();
        chk("midreset_buf", 32'(dct_buffer), 32'h00000005);
        chk("midreset_cnt", 32'(dct_count), 32'd2);
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) send_atom(2'b01);
        // Sixteenth atom arrives while the first word is being accepted.
        send_atom(2'b11);
        chk("b2b_first_gone", 32'(dct_valid), 32'd0);
        // Stall output, then flush: request must stay pending until accepted.
        out_ready = 1'b0;
        pulse_flush();
        chk("b2b_flush_word", 32'(dct_buffer), 32'h00000003);
        chk("b2b_flush_cnt", 32'(dct_count), 32'd1);
        send_atom(2'b10);
        pulse_flush();
        step();
        chk("b2b_stable_buf", 32'(dct_buffer), 32'h00000003);
        out_ready = 1'b1;
        step();
        chk("b2b_pending_flush_buf", 32'(dct_buffer), 32'h00000002);
        chk("b2b_pending_flush_valid", 32'(dct_valid), 32'd1);
    endtask

    // Sequencer and final report
    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        atom_valid = 1'b0;
        atom_data  = 2'd0;
        flush      = 1'b0;
        end_req    = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_end();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
